pid_ctrl: RTL and testbench

//   Closed-loop steering controller for the line-follower. Takes signed line-position

---
 rtl/pid_ctrl.sv | 104 ++++++++++
 tb/tb_pid_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pid_ctrl.sv
// rtl/pid_ctrl.sv - saturated P+I+D steering controller driving left/right wheel speeds
// Optional PID_RAMP_EN: forward speed ramps up from 0 on accepted samples instead of being constant.
module pid_ctrl #(
  parameter logic [3:0]  P_COEFF   = 4'd6,
  parameter logic [3:0]  D_COEFF   = 4'd7,
  parameter logic [11:0] FRWRD_SPD = 12'h400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        err_vld,
  input  logic [15:0] error,
  input  logic        line_present,
  output logic [11:0] lft_spd,
  output logic [11:0] right_spd
);

  logic signed [9:0]  err_sat, err_reg, prev_err;
  logic signed [15:0] integrator, integ_ext, integ_sum;
  logic               integ_ovf, line_q, line_rise, sample;
  logic signed [10:0] diff;
  logic signed [7:0]  diff_sat;
  logic signed [13:0] p_term, i_term, d_term, pid;
  logic        [14:0] fwd, lft_raw, right_raw;
  logic        [11:0] fwd_spd, lft_clamp, right_clamp;

  function automatic logic [11:0] clamp12(input logic [14:0] v);
    if (v[14])              return 12'h000;
    else if (v[13:12] != 0) return 12'hFFF;
    else                    return v[11:0];
  endfunction

  always_comb begin
    if ($signed(error) > 16'sd511)       err_sat = 10'h1FF;
    else if ($signed(error) < -16'sd512) err_sat = 10'h200;
    else                                 err_sat = error[9:0];
  end

  assign sample    = go & err_vld;
  assign line_rise = line_present & ~line_q;

  // Signed overflow: both operands share a sign the sum does not; the integrator then holds.
  assign integ_ext = {{6{err_sat[9]}}, err_sat};
  assign integ_sum = integrator + integ_ext;
  assign integ_ovf = (integrator[15] == integ_ext[15]) && (integ_sum[15] != integrator[15]);

  assign p_term = $signed({{4{err_reg[9]}}, err_reg}) * $signed({10'd0, P_COEFF});
  assign i_term = $signed({{2{integrator[15]}}, integrator[15:4]});
  assign diff   = $signed({err_reg[9], err_reg}) - $signed({prev_err[9], prev_err});

  always_comb begin
    if (diff > 11'sd127)       diff_sat = 8'h7F;
    else if (diff < -11'sd128) diff_sat = 8'h80;
    else                       diff_sat = diff[7:0];
  end

  assign d_term = $signed({{6{diff_sat[7]}}, diff_sat}) * $signed({10'd0, D_COEFF});
  assign pid    = p_term + i_term + d_term;

  assign fwd         = {3'b000, fwd_spd};
  assign lft_raw     = fwd + {pid[13], pid};
  assign right_raw   = fwd - {pid[13], pid};
  assign lft_clamp   = clamp12(lft_raw);
  assign right_clamp = clamp12(right_raw);

`ifdef PID_RAMP_EN
  logic [11:0] ramp;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                               ramp <= '0;
    else if (!go)                            ramp <= '0;
    else if (err_vld && ramp < FRWRD_SPD)    ramp <= ramp + 12'd1;
  end

  assign fwd_spd = ramp;
`else
  assign fwd_spd = FRWRD_SPD;
`endif

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_reg    <= '0;
      prev_err   <= '0;
      integrator <= '0;
      line_q     <= 1'b0;
      lft_spd    <= '0;
      right_spd  <= '0;
    end else begin
      line_q <= line_present;
      if (sample) begin
        err_reg  <= err_sat;
        prev_err <= err_reg;
      end
      if (!go || line_rise)
        integrator <= '0;
      else if (sample && !integ_ovf)
        integrator <= integ_sum;
      lft_spd   <= go ? lft_clamp : 12'h000;
      right_spd <= go ? right_clamp : 12'h000;
    end
  end

endmodule

// File: tb/tb_pid_ctrl.sv
// tb/tb_pid_ctrl.sv - randomized and directed bench for pid_ctrl against an integer reference model
module tb_pid_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        err_vld = 1'b0;
  logic [15:0] error = '0;
  logic        line_present = 1'b0;
  logic [11:0] lft_spd, right_spd;

  int checks = 0;
  int failures = 0;

  int m_err, m_prev, m_int, m_line, m_l, m_r;

  pid_ctrl dut (
    .clk(clk), .rst_n(rst), .go(go), .err_vld(err_vld), .error(error),
    .line_present(line_present), .lft_spd(lft_spd), .right_spd(right_spd)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference: outputs computed from pre-edge state, then state advanced.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_err = 0; m_prev = 0; m_int = 0; m_line = 0; m_l = 0; m_r = 0;
    end else begin : mdl
      int pid, sat, s, e;
      pid = m_err * 6 + (m_int >>> 4) + clampi(m_err - m_prev, -128, 127) * 7;
      m_l = go ? clampi(1024 + pid, 0, 4095) : 0;
      m_r = go ? clampi(1024 - pid, 0, 4095) : 0;
      e   = int'($signed(error));
      sat = clampi(e, -512, 511);
      if (!go || (line_present && m_line == 0)) m_int = 0;
      else if (err_vld) begin
        s = m_int + sat;
        if (s >= -32768 && s <= 32767) m_int = s;
      end
      if (go && err_vld) begin
        m_prev = m_err;
        m_err  = sat;
      end
      m_line = line_present ? 1 : 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("lft_model", int'(lft_spd), m_l);
    check("rgt_model", int'(right_spd), m_r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_lft", int'(lft_spd), 0);
    check("rst_rgt", int'(right_spd), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_lft", int'(lft_spd), 0);
    check("reset_rgt", int'(right_spd), 0);
    check("reset_int", int'($signed(dut.integrator)), 0);
    step();
    rst = 1'b0;

    // zero error held: steady forward speed
    go = 1'b1; err_vld = 1'b1; error = 16'h0000;
    step();
    for (int i = 0; i < 1023; i++) begin
      step();
      check("t1_lft", int'(lft_spd), 12'h400);
      check("t1_rgt", int'(right_spd), 12'h400);
    end

    // two consecutive samples of 16 from zero state
    do_reset();
    go = 1'b1; err_vld = 1'b1; error = 16'h0010;
    step();
    step();
    check("t2a_lft", int'(lft_spd), 12'h4D1);
    check("t2a_rgt", int'(right_spd), 12'h32F);
    err_vld = 1'b0;
    step();
    check("t2b_lft", int'(lft_spd), 12'h462);
    check("t2b_rgt", int'(right_spd), 12'h39E);

    // large error saturates, integrator saturates without wrapping
    do_reset();
    go = 1'b1; err_vld = 1'b1; error = 16'h7FFF;
    step();
    err_vld = 1'b0;
    step();
    check("t3_lft", int'(lft_spd), 12'hFFF);
    check("t3_rgt", int'(right_spd), 12'h000);
    err_vld = 1'b1;
    for (int i = 0; i < 10000; i++) step();
    check("t3_int_max", int'($signed(dut.integrator)), 32704);
    check("t3_int_model", int'($signed(dut.integrator)), m_int);

    // go low for one cycle clears integrator and stops motors
    go = 1'b0;
    step();
    check("t4_lft", int'(lft_spd), 0);
    check("t4_rgt", int'(right_spd), 0);
    check("t4_int", int'($signed(dut.integrator)), 0);
    go = 1'b1; error = 16'h0000;
    step(); step(); step();
    check("t4_lft_back", int'(lft_spd), 12'h400);
    check("t4_rgt_back", int'(right_spd), 12'h400);

    // line_present rise clears integrator once
    line_present = 1'b1; error = 16'd200;
    for (int i = 0; i < 5; i++) step();
    line_present = 1'b0;
    step();
    check("t5_int_pre", int'($signed(dut.integrator)), m_int);
    line_present = 1'b1;
    step();
    check("t5_int_clr", int'($signed(dut.integrator)), 0);
    step();
    check("t5_int_hold", int'($signed(dut.integrator)), 200);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      go      = ($urandom_range(0, 15) != 0);
      err_vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) error = 16'($urandom);
      else error = 16'($signed($urandom_range(0, 1400)) - 700);
      if ($urandom_range(0, 7) == 0) line_present = ~line_present;
      step();
      if (i % 64 == 0) check("rand_int", int'($signed(dut.integrator)), m_int);
    end

    // asynchronous reset mid-run
    go = 1'b1; err_vld = 1'b1; error = 16'd300; line_present = 1'b1;
    step(); step();
    check("t6_pre_lft", int'(lft_spd), m_l);
    #2 rst = 1'b1;
    #1;
    check("t6_lft", int'(lft_spd), 0);
    check("t6_rgt", int'(right_spd), 0);
    check("t6_int", int'($signed(dut.integrator)), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
